serial_mod_n_detector: RTL



---
 rtl/serial_mod_n_detector.sv | 79 +++++++
 1 files changed

// File: rtl/serial_mod_n_detector.sv
// Bit-serial divisibility checker: tracks the running value modulo N one bit at a time,
// MSB-first or LSB-first, and flags when the value received so far is divisible by N.
module serial_mod_n_detector #(
  parameter int unsigned N         = 3,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RW        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr,
  output logic             z,
  output logic [RW-1:0]    rem,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned      XW      = RW + 1;
  localparam logic [XW-1:0]    N_X     = XW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RW-1:0]    r_rem;
  logic [RW-1:0]    r_w;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;

  logic [RW-1:0]    w_rem_base;
  logic [RW-1:0]    w_w_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic [XW-1:0]    w_sum;
  logic [XW-1:0]    w_dbl;
  logic [RW-1:0]    w_rem_nxt;
  logic [RW-1:0]    w_w_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A clear in the same cycle as a valid bit makes that bit the first of a new number.
  always_comb begin
    w_rem_base = clr ? '0 : r_rem;
    w_w_base   = clr ? RW'(1) : r_w;
    w_cnt_base = clr ? '0 : r_cnt;

    if (LSB_FIRST != 0) begin
      w_sum = {1'b0, w_rem_base} + (x ? {1'b0, w_w_base} : '0);
    end else begin
      w_sum = {w_rem_base, x};
    end
    w_dbl = {w_w_base, 1'b0};

    // Both intermediates are below 2N, so one conditional subtract reduces them.
    w_rem_nxt = (w_sum >= N_X) ? RW'(w_sum - N_X) : RW'(w_sum);
    w_w_nxt   = (w_dbl >= N_X) ? RW'(w_dbl - N_X) : RW'(w_dbl);
    w_cnt_nxt = (w_cnt_base == CNT_MAX) ? w_cnt_base : w_cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_w   <= RW'(1);
      r_z   <= 1'b0;
      r_cnt <= '0;
    end else if (x_valid) begin
      r_rem <= w_rem_nxt;
      r_w   <= w_w_nxt;
      r_z   <= (w_rem_nxt == '0);
      r_cnt <= w_cnt_nxt;
    end else if (clr) begin
      r_rem <= '0;
      r_w   <= RW'(1);
      r_z   <= 1'b0;
      r_cnt <= '0;
    end
  end

  assign z         = r_z;
  assign rem       = r_rem;
  assign bit_count = r_cnt;

endmodule
